// File: rtl/bfly2_out_sched_if.sv
// rtl/bfly2_out_sched_if.sv - input/output stream bundle of the butterfly output scheduler
//
// Purpose : carries one beat of butterfly outputs in and one beat of rescaled samples out.
// Signals : in_valid/in_ready    - input beat handshake
//           sum_re/sum_im        - LANES x (WIDTH+1) butterfly sum outputs
//           dif_re/dif_im        - LANES x (WIDTH+1) butterfly difference outputs
//           out_valid/out_ready  - output beat handshake
//           out_re/out_im        - LANES x WIDTH rescaled samples
//           out_half             - 0 = sums, 1 = differences
//           out_last             - final beat of the frame
// Modports: master = upstream/downstream side, slave = the scheduler.
interface bfly2_out_sched_if #(
    parameter int WIDTH = 10,
    parameter int LANES = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES-1:0][WIDTH:0]     sum_re;
    logic [LANES-1:0][WIDTH:0]     sum_im;
    logic [LANES-1:0][WIDTH:0]     dif_re;
    logic [LANES-1:0][WIDTH:0]     dif_im;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES-1:0][WIDTH-1:0]   out_re;
    logic [LANES-1:0][WIDTH-1:0]   out_im;
    logic                          out_half;
    logic                          out_last;

    modport master (
        output in_valid, sum_re, sum_im, dif_re, dif_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_half, out_last
    );

    modport slave (
        input  in_valid, sum_re, sum_im, dif_re, dif_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_half, out_last
    );
endinterface

// File: rtl/bfly2_out_sched.sv
// rtl/bfly2_out_sched.sv - radix-2 butterfly output rescaler and natural-order scheduler
//
// Purpose : accepts one beat of LANES sums and differences per cycle, rescales every
//           value to WIDTH bits, forwards sums at once and buffers the differences.
//           After DEPTH input beats the buffered differences are drained, so each
//           frame leaves as DEPTH sum beats followed by DEPTH difference beats.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - bfly2_out_sched_if.slave (input beat stream, output beat stream)
module bfly2_out_sched #(
    parameter int SIG   = 1,
    parameter int INT   = 3,
    parameter int FLT   = 6,
    parameter int WIDTH = SIG + INT + FLT,
    parameter int LANES = 16,
    parameter int DEPTH = 4,
    parameter int SCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bfly2_out_sched_if.slave bus
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef logic [LANES-1:0][WIDTH-1:0] beat_t;
    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   ptr;
    beat_t           buf_re [DEPTH];
    beat_t           buf_im [DEPTH];
    beat_t           sum_re_s;
    beat_t           sum_im_s;
    beat_t           dif_re_s;
    beat_t           dif_im_s;

    logic            out_valid_q;
    logic            out_half_q;
    logic            out_last_q;
    beat_t           out_re_q;
    beat_t           out_im_q;

    logic            adv;
    logic            in_ready_c;
    logic            accept;
    logic            load_drain;
    logic            cnt_last;
    logic            ptr_last;

    // SCALE!=0: (x+1)>>>1 computed one bit wider so +1 on the max value cannot wrap.
    // Both modes then share one clamp: the result fits WIDTH bits exactly when its
    // two top bits agree.
    function automatic logic [WIDTH-1:0] rescale(input logic [WIDTH:0] x);
        logic [WIDTH+1:0] t;
        logic [WIDTH:0]   y;
        logic [WIDTH-1:0] r;
        t = {x[WIDTH], x} + {{(WIDTH+1){1'b0}}, 1'b1};
        y = (SCALE != 0) ? t[WIDTH+1:1] : x;
        if (y[WIDTH] != y[WIDTH-1]) begin
            r = y[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            r = y[WIDTH-1:0];
        end
        return r;
    endfunction

    always_comb begin
        sum_re_s = '0;
        sum_im_s = '0;
        dif_re_s = '0;
        dif_im_s = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_re_s[l] = rescale(bus.sum_re[l]);
            sum_im_s[l] = rescale(bus.sum_im[l]);
            dif_re_s[l] = rescale(bus.dif_re[l]);
            dif_im_s[l] = rescale(bus.dif_im[l]);
        end
    end

    // The output register may take a new beat when it is empty or being consumed.
    assign adv        = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_c;
    assign load_drain = (state == DRAIN) && adv;
    assign cnt_last   = (cnt == LAST_IDX);
    assign ptr_last   = (ptr == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        case (state)
            FILL: begin
                in_ready_c = adv;
                if (bus.in_valid && adv && cnt_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (adv && ptr_last) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ptr <= '0;
        end else begin
            if (accept) begin
                cnt <= cnt_last ? '0 : cnt + 1'b1;
            end
            if (load_drain) begin
                ptr <= ptr_last ? '0 : ptr + 1'b1;
            end
        end
    end

    // Buffer holds post-rescale differences; written only in FILL, read only in DRAIN.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_re[cnt] <= dif_re_s;
            buf_im[cnt] <= dif_im_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_half_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else if (adv) begin
            if (load_drain) begin
                out_valid_q <= 1'b1;
                out_half_q  <= 1'b1;
                out_last_q  <= ptr_last;
                out_re_q    <= buf_re[ptr];
                out_im_q    <= buf_im[ptr];
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_half_q  <= 1'b0;
                out_last_q  <= 1'b0;
                out_re_q    <= sum_re_s;
                out_im_q    <= sum_im_s;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_half  = out_half_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;

endmodule
